// File: rtl/dadda_mac_ctrl_if.sv
// Handshake and multiplier bus for dadda_mac_ctrl: upstream operands, multiplier
// operand/product pair and downstream accumulated result.
interface dadda_mac_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_last;
  logic [WIDTH-1:0]     mul_in1;
  logic [WIDTH-1:0]     mul_in2;
  logic [2*WIDTH-1:0]   mul_prod;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;
  logic [LEN_W-1:0]     out_count;
  logic                 out_sat;

  // Controller side
  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_prod, out_ready,
    output in_ready, mul_in1, mul_in2, out_valid, out_acc, out_count, out_sat
  );

  // Producer / multiplier / consumer side
  modport master (
    output in_valid, in_a, in_b, in_last, mul_prod, out_ready,
    input  in_ready, mul_in1, mul_in2, out_valid, out_acc, out_count, out_sat
  );
endinterface

// File: rtl/dadda_mac_ctrl.sv
// Operand issue, settle wait and burst accumulation around an external combinational Dadda multiplier.
// Optional macro DADDA_MAC_SAT_EN: saturate the accumulator on carry-out and report it on out_sat.
module dadda_mac_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dadda_mac_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  generate
    if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
      $error("dadda_mac_ctrl: ACC_W must be >= 2*WIDTH");
    end
    if (MUL_LAT < 1) begin : g_bad_mul_lat
      $error("dadda_mac_ctrl: MUL_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_mul_in1;
  logic [WIDTH-1:0] r_mul_in2;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_count;
  logic             r_sat;

  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_sat_nxt;
  logic [LEN_W-1:0] w_count_nxt;

`ifdef DADDA_MAC_SAT_EN
  // One extra bit catches the carry-out; a saturated accumulator stays at all-ones.
  logic [ACC_W:0] w_sum;
  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(bus.mul_prod);
  assign w_acc_nxt = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_sat_nxt = r_sat | w_sum[ACC_W];
`else
  assign w_acc_nxt = r_acc + ACC_W'(bus.mul_prod);
  assign w_sat_nxt = 1'b0;
`endif

  assign w_count_nxt = (r_count == {LEN_W{1'b1}}) ? r_count : r_count + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mul_in1   <= '0;
      r_mul_in2   <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_mul_in1  <= bus.in_a;
            r_mul_in2  <= bus.in_b;
            r_last     <= bus.in_last;
            r_cnt      <= CNT_W'(MUL_LAT);
            r_in_ready <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc   <= w_acc_nxt;
          r_count <= w_count_nxt;
          r_sat   <= w_sat_nxt;
          if (r_last) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mul_in1   = r_mul_in1;
  assign bus.mul_in2   = r_mul_in2;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_acc;
  assign bus.out_count = r_count;
  assign bus.out_sat   = r_sat;
endmodule
